pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, fetch-wait limit in cycles; used only with FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 next_pc  input  32  next PC from the next-PC select mux (jump/branch/PC+4 resolved).
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  32  instruction memory word address; equals pc.
REQ-008 imem_ack  input  1  memory has returned data for the current request.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-010 pc  output  32  current PC register.
REQ-011 instr  output  32  captured instruction word.
REQ-012 instr_valid  output  1  instr/pc hold a fetched instruction for the datapath.
REQ-013 instr_ready  input  1  datapath consumes the instruction this cycle.
REQ-014 retire_count  output  32  number of accepted instructions.
REQ-015 fault  output  1  sticky fault; fetch halted.
REQ-016 fault_code  output  2  01 misaligned next_pc, 10 fetch timeout, 00 none.

Function
REQ-017 FSM states SHALL be FETCH, HOLD, HALT; reset state FETCH.
REQ-018 FETCH: imem_req=1, instr_valid=0; on imem_ack=1, instr<=imem_rdata and go to HOLD next cycle.
REQ-019 Zero-wait memory (imem_ack=1 in first FETCH cycle) SHALL give instr_valid=1 on the following cycle; minimum 2 cycles per instruction.
REQ-020 HOLD: imem_req=0, instr_valid=1; instr and pc SHALL stay stable until instr_ready=1.
REQ-021 HOLD with instr_ready=1: pc<=next_pc, retire_count<=retire_count+1 (wraps 2^32-1 to 0), go to FETCH if next_pc[1:0]==00.
REQ-022 HOLD with instr_ready=1 and next_pc[1:0]!=00: pc<=next_pc, retire_count increments, go to HALT, fault<=1, fault_code<=01.
REQ-023 HALT: imem_req=0, instr_valid=0, all registers frozen; exit only by reset.
REQ-024 imem_ack or instr_ready outside the state that samples it SHALL be ignored.
REQ-025 imem_addr SHALL equal pc combinationally in all states.

Reset
REQ-026 rst_n low SHALL immediately set pc=RESET_PC, instr=0, state=FETCH, retire_count=0, fault=0, fault_code=00, timeout counter=0.
REQ-027 Outputs during reset: imem_req=0, instr_valid=0; imem_req rises on first clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-fetch or mid-HOLD SHALL abandon the transaction; a late imem_ack after reset release with no new request cycle is not possible since FETCH restarts cleanly at RESET_PC.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN defined: counter clears on FETCH entry, increments each FETCH cycle without imem_ack; reaching TIMEOUT_CYCLES without ack -> HALT, fault=1, fault_code=10.
REQ-030 FETCH_TIMEOUT_EN undefined: no counter, FETCH waits indefinitely, fault_code=10 never produced.

Verification
REQ-031 Reset release, imem_ack tied 1, instr_ready tied 1, next_pc=pc+4 -> imem_addr 0,4,8 every 2 cycles; retire_count 1,2,3.
REQ-032 imem_ack delayed 3 cycles, imem_rdata=32'h2002_0005 -> imem_req held 4 cycles, instr=32'h2002_0005, instr_valid on cycle 5.
REQ-033 instr_ready held 0 for 5 cycles in HOLD -> instr, pc unchanged, imem_req=0, retire_count unchanged.
REQ-034 next_pc=32'h0000_0102 on accept -> pc=32'h0000_0102, fault=1, fault_code=01, imem_req stays 0.
REQ-035 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, imem_ack never asserted -> fault=1, fault_code=10 after 16 FETCH cycles; without macro imem_req stays 1 for 100 cycles, fault=0.
REQ-036 rst_n pulsed low during HOLD at pc=32'h40 -> pc=RESET_PC, instr_valid=0 immediately, retire_count=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Purpose   : program-counter register and instruction fetch sequencer (FETCH -> HOLD -> FETCH).
// Latency   : at least 2 cycles per instruction; instr_valid rises the cycle after imem_ack.
// Backpress : instr/pc hold stable in HOLD until instr_ready; a misaligned next_pc halts fetch.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   next_pc               next PC from the next-PC mux, taken when an instruction is accepted
//   imem_req/imem_addr    instruction memory request; imem_addr always mirrors pc
//   imem_ack/imem_rdata   memory response for the outstanding request
//   pc/instr/instr_valid  fetched instruction presented to the datapath
//   instr_ready           datapath accepts the presented instruction
//   retire_count          accepted-instruction counter (wraps)
//   fault/fault_code      sticky halt indication: 01 misaligned next_pc, 10 fetch timeout
//
// Build option: define FETCH_TIMEOUT_EN to halt with fault_code 10 when memory
// fails to acknowledge within TIMEOUT_CYCLES fetch cycles.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] retire_count,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    // A zero or negative timeout cannot be honoured; stop elaboration early.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("pc_fetch_unit: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retire_q;
    logic        fault_q;
    logic [1:0]  code_q;
    // Cleared by reset, set by the first clock edge afterwards. Keeps imem_req low
    // while reset is asserted and until the first edge after release, so the first
    // request cycle always starts cleanly at RESET_PC.
    logic        run_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_q;
`endif

    assign imem_req     = run_q && (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = (state_q == HOLD);
    assign retire_count = retire_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            retire_q <= 32'h0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
            run_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            run_q <= 1'b1;
            case (state_q)
                FETCH: begin
                    // Responses are only meaningful while a request is actually out.
                    if (run_q) begin
                        if (imem_ack) begin
                            instr_q <= imem_rdata;
                            state_q <= HOLD;
                        end
`ifdef FETCH_TIMEOUT_EN
                        else if (wait_q == TO_LAST) begin
                            state_q <= HALT;
                            fault_q <= 1'b1;
                            code_q  <= CODE_TIMEOUT;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        // The instruction retires even when its successor is misaligned;
                        // pc still takes next_pc so the offending address is visible.
                        pc_q     <= next_pc;
                        retire_q <= retire_q + 32'd1;
                        if (next_pc[1:0] == 2'b00) begin
                            state_q <= FETCH;
`ifdef FETCH_TIMEOUT_EN
                            wait_q  <= '0;
`endif
                        end else begin
                            state_q <= HALT;
                            fault_q <= 1'b1;
                            code_q  <= CODE_MISALIGN;
                        end
                    end
                end
                HALT: begin
                    // Frozen until reset.
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose   : self-checking bench for pc_fetch_unit against a transaction-level model.
// Latency   : model expects ack-delay+1 request cycles, then a HOLD of ready-delay+1 cycles.
// Backpress : instr_ready is withheld for random spans; ignored inputs are randomised.

module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] retire_count;
    logic        fault;
    logic [1:0]  fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural PC and number of accepted instructions.
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_pc      (next_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .retire_count (retire_count),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset (checking its immediate effect), release it, and check that the
    // request appears only after the first edge following release.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_pc",    pc,                   RESET_PC);
        chk("rst_instr", instr,                32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_ret",   retire_count,         32'd0);
        chk("rst_fault", {31'd0, fault},       32'd0);
        chk("rst_code",  {30'd0, fault_code},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pc  = RESET_PC;
        m_ret = 32'd0;
        chk("rel_req_low", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rel_req_high", {31'd0, imem_req}, 32'd1);
        chk("rel_addr",     imem_addr,         RESET_PC);
    endtask

    // One instruction: memory answers after d idle request cycles, the datapath
    // stalls w cycles in HOLD, then accepts with next_pc = npc.
    task automatic do_instr(input int d, input int w, input logic [31:0] npc, input logic [31:0] data);
        for (int k = 0; k < d; k++) begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            next_pc     = $urandom;
            chk("fetch_req",   {31'd0, imem_req},    32'd1);
            chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
            chk("fetch_addr",  imem_addr,            m_pc);
            tick();
        end
        chk("fetch_req",  {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr,         m_pc);
        imem_ack    = 1'b1;
        imem_rdata  = data;
        instr_ready = 1'($urandom_range(0, 1));
        tick();
        imem_rdata = $urandom;
        for (int k = 0; k < w; k++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom_range(0, 1));
            next_pc     = $urandom;
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_req",   {31'd0, imem_req},    32'd0);
            chk("hold_instr", instr,                data);
            chk("hold_pc",    pc,                   m_pc);
            chk("hold_ret",   retire_count,         m_ret);
            tick();
        end
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr,                data);
        instr_ready = 1'b1;
        next_pc     = npc;
        imem_ack    = 1'($urandom_range(0, 1));
        tick();
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        m_pc  = npc;
        m_ret = m_ret + 32'd1;
        chk("acc_pc",  pc,           m_pc);
        chk("acc_ret", retire_count, m_ret);
        if (npc[1:0] == 2'b00) begin
            chk("acc_req",   {31'd0, imem_req}, 32'd1);
            chk("acc_fault", {31'd0, fault},    32'd0);
        end else begin
            chk("mis_req",   {31'd0, imem_req},    32'd0);
            chk("mis_valid", {31'd0, instr_valid}, 32'd0);
            chk("mis_fault", {31'd0, fault},       32'd1);
            chk("mis_code",  {30'd0, fault_code},  32'd1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        next_pc     = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        m_pc        = RESET_PC;
        m_ret       = 32'd0;

        // Power-on reset.
        do_reset();

        // Zero-wait memory, always-ready datapath, sequential PCs: 0,4,8.
        for (int i = 0; i < 3; i++) do_instr(0, 0, m_pc + 32'd4, $urandom);
        chk("seq_ret3", retire_count, 32'd3);
        chk("seq_addr", imem_addr,    32'd12);

        // Memory answers after three idle request cycles.
        do_instr(3, 0, m_pc + 32'd4, 32'h2002_0005);

        // Datapath stalls five cycles in HOLD.
        do_instr(1, 5, m_pc + 32'd4, $urandom);

        // Randomised traffic with aligned branch targets.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] t;
            t = $urandom;
            t[1:0] = 2'b00;
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), t, $urandom);
        end

        // Reset pulsed while an instruction at 0x40 is held.
        do_instr(0, 0, 32'h0000_0040, $urandom);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0040;
        tick();
        imem_ack = 1'b0;
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        chk("pre_rst_pc",    pc,                   32'h0000_0040);
        do_reset();

        // Memory never acknowledges.
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait_req",   {31'd0, imem_req}, 32'd1);
            chk("to_wait_fault", {31'd0, fault},    32'd0);
        end
        tick();
        chk("to_fault", {31'd0, fault},      32'd1);
        chk("to_code",  {30'd0, fault_code}, 32'd2);
        chk("to_req",   {31'd0, imem_req},   32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("noto_req",   {31'd0, imem_req}, 32'd1);
            chk("noto_fault", {31'd0, fault},    32'd0);
        end
`endif
        do_reset();

        // Misaligned successor halts fetch; everything then stays frozen.
        do_instr(0, 1, m_pc + 32'd4, $urandom);
        do_instr(2, 0, 32'h0000_0102, $urandom);
        chk("mis_pc", pc, 32'h0000_0102);
        for (int i = 0; i < 6; i++) begin
            imem_ack    = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            next_pc     = $urandom;
            tick();
            chk("halt_pc",    pc,                   32'h0000_0102);
            chk("halt_req",   {31'd0, imem_req},    32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_ret",   retire_count,         m_ret);
            chk("halt_fault", {31'd0, fault},       32'd1);
            chk("halt_code",  {30'd0, fault_code},  32'd1);
        end

        // Reset recovers from the halt.
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        do_instr(0, 0, m_pc + 32'd4, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
